// File: rtl/issue_scheduler_rr.sv
// Round-robin issue selector for a 16-entry reservation station.
// It holds one selected entry until the functional unit accepts it, then loads the next candidate.
module issue_scheduler_rr (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ready,
    input  logic        fu_ready,
    input  logic        flush,
    output logic        issue_valid,
    output logic [15:0] issue_grant,
    output logic [4:0]  issue_idx,
    output logic [15:0] entry_clr,
    output logic [3:0]  rr_ptr
);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t      state;
    logic        handshake;
    logic [3:0]  search_start;
    logic [15:0] search_mask;
    logic [4:0]  pick;

    // Returns the first set bit at or after start (wrapping), or 16 when req is empty.
    function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] start);
        logic [4:0] sel;
        logic       found;
        logic [3:0] k;
        sel   = 5'd16;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            k = start + 4'(i);
            if (!found && req[k]) begin
                sel   = {1'b0, k};
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign issue_valid = (state == HOLD);
    assign handshake   = issue_valid && fu_ready && !flush && RESET;
    assign entry_clr   = handshake ? issue_grant : 16'h0000;

    // After a handshake the search starts from the freshly advanced pointer.
    always_comb begin
        search_start = rr_ptr;
        search_mask  = 16'h0000;
        if (issue_valid)
            search_mask = issue_grant;
        if (handshake)
            search_start = issue_idx[3:0] + 4'd1;
        pick = rr_pick(ready & ~search_mask, search_start);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= EMPTY;
            issue_grant <= 16'h0000;
            issue_idx   <= 5'd16;
            rr_ptr      <= 4'd0;
        end else if (flush) begin
            state       <= EMPTY;
            issue_grant <= 16'h0000;
            issue_idx   <= 5'd16;
        end else begin
            case (state)
                EMPTY: begin
                    if (pick != 5'd16) begin
                        state       <= HOLD;
                        issue_grant <= 16'h0001 << pick[3:0];
                        issue_idx   <= pick;
                    end
                end
                HOLD: begin
                    if (fu_ready) begin
                        rr_ptr <= issue_idx[3:0] + 4'd1;
                        if (pick != 5'd16) begin
                            issue_grant <= 16'h0001 << pick[3:0];
                            issue_idx   <= pick;
                        end else begin
                            state       <= EMPTY;
                            issue_grant <= 16'h0000;
                            issue_idx   <= 5'd16;
                        end
                    end
                end
                default: begin
                    state       <= EMPTY;
                    issue_grant <= 16'h0000;
                    issue_idx   <= 5'd16;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_scheduler_rr.sv
// Bench for issue_scheduler_rr: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the selection rules.
module tb_issue_scheduler_rr;

    logic        CLK;
    logic        RESET;
    logic [15:0] ready;
    logic        fu_ready;
    logic        flush;
    logic        issue_valid;
    logic [15:0] issue_grant;
    logic [4:0]  issue_idx;
    logic [15:0] entry_clr;
    logic [3:0]  rr_ptr;

    int checks = 0;
    int errors = 0;

    // Model state: held entry (-1 when nothing is presented) and search pointer.
    int m_held = -1;
    int m_ptr  = 0;

    issue_scheduler_rr dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ready      (ready),
        .fu_ready   (fu_ready),
        .flush      (flush),
        .issue_valid(issue_valid),
        .issue_grant(issue_grant),
        .issue_idx  (issue_idx),
        .entry_clr  (entry_clr),
        .rr_ptr     (rr_ptr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [15:0] req, input int start, input int excl);
        for (int k = 0; k < 16; k++) begin
            int j;
            j = (start + k) % 16;
            if (req[j] && j != excl)
                return j;
        end
        return -1;
    endfunction

    // One clock cycle: apply inputs, check the combinational free pulse, advance model, check registers.
    task automatic step(input logic rst_n, input logic [15:0] rdy, input logic fu, input logic fl);
        logic [15:0] exp_clr;
        RESET    = rst_n;
        ready    = rdy;
        fu_ready = fu;
        flush    = fl;
        #1;
        exp_clr = (rst_n && m_held >= 0 && fu && !fl) ? (16'h0001 << m_held) : 16'h0000;
        chk("entry_clr", 32'(entry_clr), 32'(exp_clr));
        if (!rst_n) begin
            m_held = -1;
            m_ptr  = 0;
        end else if (fl) begin
            m_held = -1;
        end else if (m_held < 0) begin
            m_held = first_from(rdy, m_ptr, -1);
        end else if (fu) begin
            m_ptr  = (m_held + 1) % 16;
            m_held = first_from(rdy, m_ptr, m_held);
        end
        @(posedge CLK);
        #1;
        chk("issue_valid", 32'(issue_valid), (m_held >= 0) ? 32'd1 : 32'd0);
        chk("issue_idx",   32'(issue_idx),   (m_held >= 0) ? 32'(m_held) : 32'd16);
        chk("issue_grant", 32'(issue_grant), (m_held >= 0) ? (32'd1 << m_held) : 32'd0);
        chk("rr_ptr",      32'(rr_ptr),      32'(m_ptr));
        @(negedge CLK);
    endtask

    initial begin
        logic [15:0] r;
        RESET = 1'b0; ready = 16'h0000; fu_ready = 1'b0; flush = 1'b0;
        @(negedge CLK);

        // Reset then idle.
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0000, 1'b0, 1'b0);

        // Two requesters alternate under constant acceptance.
        for (int i = 0; i < 5; i++) step(1'b1, 16'h8001, 1'b1, 1'b0);
        chk("alt_idx_const", 32'(issue_idx), 32'd0);
        step(1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 1'b0, 1'b0);

        // Held selection survives ready dropping while the FU stalls.
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        chk("hold_idx_const", 32'(issue_idx), 32'd4);
        step(1'b1, 16'h0000, 1'b1, 1'b0);
        chk("hold_ptr_const", 32'(rr_ptr), 32'd5);
        step(1'b1, 16'h0000, 1'b0, 1'b0);

        // Pointer wrap from 15 back to 0.
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h4000, 1'b0, 1'b0);
        step(1'b1, 16'h8002, 1'b1, 1'b0);
        chk("wrap_ptr15_const", 32'(rr_ptr), 32'd15);
        step(1'b1, 16'h8002, 1'b1, 1'b0);
        step(1'b1, 16'h0002, 1'b1, 1'b0);
        chk("wrap_ptr2_const", 32'(rr_ptr), 32'd2);

        // Flush coinciding with a handshake.
        step(1'b1, 16'h0080, 1'b0, 1'b0);
        step(1'b1, 16'h0080, 1'b1, 1'b1);
        step(1'b1, 16'h0000, 1'b0, 1'b0);

        // Reset pulse while holding, then reissue.
        step(1'b1, 16'h0008, 1'b0, 1'b0);
        step(1'b1, 16'h0008, 1'b0, 1'b0);
        step(1'b0, 16'h0008, 1'b1, 1'b0);
        step(1'b1, 16'h0008, 1'b0, 1'b0);
        chk("reissue_idx_const", 32'(issue_idx), 32'd3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 16'($urandom);
            if ($urandom_range(0, 9) == 0) r = 16'h0000;
            step(($urandom_range(0, 39) != 0), r, ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 11) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scheduler_rr.md
ISSUE_SCHEDULER_RR -- requirements
Module: issue_scheduler_rr

Interface
REQ-001 The module SHALL have no parameters; the entry count is fixed at 16.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset (0 = reset asserted, sampled on CLK rising edge).
REQ-004 ready  input  16  per-entry issue request from the 16-entry reservation station; bit i = entry i operands ready.
REQ-005 fu_ready  input  1  downstream functional unit can accept an instruction this cycle.
REQ-006 flush  input  1  pipeline flush (branch mispredict); synchronous, active-high.
REQ-007 issue_valid  output  1  registered; a selected entry is presented to the FU.
REQ-008 issue_grant  output  16  registered one-hot of the presented entry; all zero when issue_valid = 0.
REQ-009 issue_idx  output  5  registered binary index 0-15 of the presented entry; 16 when issue_valid = 0.
REQ-010 entry_clr  output  16  combinational one-hot = issue_grant when issue_valid & fu_ready & !flush, else 0; frees the RS entry.
REQ-011 rr_ptr  output  4  registered round-robin search start index (debug/visibility).

Function
REQ-012 Two states SHALL exist: EMPTY (issue_valid = 0) and HOLD (issue_valid = 1).
REQ-013 Selection: the candidate SHALL be the first set bit of (ready & ~mask) scanning upward from rr_ptr, wrapping 15 -> 0; mask = issue_grant when in HOLD, else 0.
REQ-014 EMPTY: if any candidate exists, load it into issue_grant/issue_idx and go to HOLD next cycle (latency 1 cycle from ready to issue_valid); else stay EMPTY.
REQ-015 HOLD with fu_ready = 0: outputs SHALL remain stable; changes on ready (including deassertion of the held bit) SHALL NOT alter the held selection.
REQ-016 HOLD with fu_ready = 1 (handshake): entry_clr pulses the held entry; if another candidate exists (held entry excluded via mask) load it and stay HOLD (back-to-back issue, one per cycle); else go to EMPTY.
REQ-017 rr_ptr SHALL update only on a handshake, to (issued index + 1) mod 16, wrapping 15 -> 0; unchanged otherwise.
REQ-018 Selection for the next load after a handshake SHALL use the updated pointer value (issued index + 1), so the same entry never wins twice in a row while others request.
REQ-019 flush = 1 SHALL force EMPTY next cycle, issue_valid = 0, issue_grant = 0, issue_idx = 16, entry_clr = 0; rr_ptr unchanged; no new selection loaded that cycle.
REQ-020 flush and handshake in the same cycle: flush wins; no entry_clr, rr_ptr unchanged.
REQ-021 issue_grant SHALL always be one-hot or zero and consistent with issue_idx and issue_valid.

Reset
REQ-022 While RESET = 0 at a rising edge: state EMPTY, issue_valid = 0, issue_grant = 0, issue_idx = 16, rr_ptr = 0.
REQ-023 Reset SHALL take priority over flush and handshake; a held selection is discarded with no entry_clr pulse while RESET = 0.
REQ-024 entry_clr SHALL be 0 whenever RESET = 0.

Verification
REQ-025 Reset then ready = 16'h0000 for 5 cycles -> issue_valid = 0, issue_idx = 16, rr_ptr = 0 throughout.
REQ-026 ready = 16'h8001, fu_ready = 1 constantly -> issue_idx sequence 0, 15, 0, 15; rr_ptr 1, 0, 1, 0; entry_clr alternates 16'h0001/16'h8000.
REQ-027 ready = 16'h0010, fu_ready = 0 for 3 cycles, ready dropped to 0 in cycle 2 -> issue_idx stays 4, issue_valid = 1; on fu_ready = 1 entry_clr = 16'h0010, rr_ptr = 5, next cycle EMPTY.
REQ-028 rr_ptr = 15, ready = 16'h8002, fu_ready = 1 -> issue 15, then wrap: rr_ptr = 0, next issue 1, rr_ptr = 2.
REQ-029 HOLD on idx 7 with fu_ready = 1 and flush = 1 same cycle -> entry_clr = 0, rr_ptr unchanged, next cycle issue_valid = 0, issue_idx = 16.
REQ-030 HOLD on idx 3, RESET = 0 for one cycle mid-operation -> issue_valid = 0, issue_idx = 16, rr_ptr = 0, no entry_clr; after release ready = 16'h0008 reissues idx 3 one cycle later.
